// File: rtl/sat_ctr_pkg.sv
// Shared types and helpers for the saturating confidence counter table.
// Widths are passed as function arguments so one package serves every
// counter width from 1 to MAX_CTR_W bits.
package sat_ctr_pkg;

    localparam int unsigned MAX_CTR_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } flush_state_t;

    // Largest value a ctr_w-bit counter can hold (CTR_MAX).
    function automatic logic [MAX_CTR_W-1:0] ctr_max(input int unsigned ctr_w);
        logic [MAX_CTR_W:0] v;
        v = (MAX_CTR_W+1)'(1) << ctr_w;
        v = v - (MAX_CTR_W+1)'(1);
        return v[MAX_CTR_W-1:0];
    endfunction

    // Smallest value considered "trusted" (TRUST_THRESH): the counter MSB.
    function automatic logic [MAX_CTR_W-1:0] trust_thresh(input int unsigned ctr_w);
        logic [MAX_CTR_W-1:0] v;
        v = MAX_CTR_W'(1) << (ctr_w - 1);
        return v;
    endfunction

    // One saturating step: count toward max on truth, toward zero otherwise.
    function automatic logic [MAX_CTR_W-1:0] sat_next(
        input logic [MAX_CTR_W-1:0] ctr,
        input logic                 truth,
        input int unsigned          ctr_w
    );
        logic [MAX_CTR_W-1:0] m;
        m = ctr_max(ctr_w);
        if (truth) begin
            return (ctr == m) ? ctr : ctr + MAX_CTR_W'(1);
        end
        return (ctr == '0) ? ctr : ctr - MAX_CTR_W'(1);
    endfunction

endpackage

// File: rtl/sat_ctr_cell.sv
// Single saturating counter. Load has priority over step so that a flush
// write always wins; both are decoded by the table top.
module sat_ctr_cell
    import sat_ctr_pkg::*;
#(
    parameter int unsigned CTR_W = 2,
    parameter int unsigned INIT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_truth,
    output logic [CTR_W-1:0] o_ctr
);

    logic [CTR_W-1:0]     r_ctr;
    logic [MAX_CTR_W-1:0] w_next_full;
    logic [CTR_W-1:0]     w_next;

    assign w_next_full = sat_next(MAX_CTR_W'(r_ctr), i_truth, CTR_W);
    assign w_next      = w_next_full[CTR_W-1:0];
    assign o_ctr       = r_ctr;

    // Counter register: reset/load to INIT, otherwise saturating step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr <= CTR_W'(INIT);
        end else if (i_load) begin
            r_ctr <= CTR_W'(INIT);
        end else if (i_step) begin
            r_ctr <= w_next;
        end
    end

endmodule

// File: rtl/sat_counter_table.sv
// Table of 2^IDX_W saturating confidence counters with a registered lookup
// port, an update port and a one-entry-per-cycle flush sweep.
// Optional build macro SAT_CTR_BYPASS_EN: a lookup colliding with an update
// on the same index returns the post-update value instead of the old one.
module sat_counter_table
    import sat_ctr_pkg::*;
#(
    parameter int unsigned CTR_W = 2,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned INIT  = (1 << CTR_W) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             pred_valid,
    output logic             pred_trust,
    output logic             pred_strong,
    output logic [CTR_W-1:0] pred_ctr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_truth,
    input  logic             flush_req,
    output logic             busy
);

    localparam int unsigned      ENTRIES  = 1 << IDX_W;
    localparam logic [CTR_W-1:0] W_MAX    = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] W_THRESH = CTR_W'(trust_thresh(CTR_W));

    flush_state_t     r_state;
    flush_state_t     w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_busy;

    logic [CTR_W-1:0] w_ctr [ENTRIES];
    logic [CTR_W-1:0] w_rd_ctr;
    logic             w_lookup_ok;

    logic             r_pred_valid;
    logic             r_pred_trust;
    logic             r_pred_strong;
    logic [CTR_W-1:0] r_pred_ctr;

    assign w_busy      = (r_state == SWEEP);
    assign busy        = w_busy;
    assign w_lookup_ok = lookup_valid && !w_busy;

    // Flush FSM state and sweep pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Flush FSM next state: start on a pulse in IDLE, leave after the last entry.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            IDLE: begin
                if (flush_req) begin
                    w_state_next = SWEEP;
                    w_ptr_next   = '0;
                end
            end
            SWEEP: begin
                w_ptr_next = r_ptr + IDX_W'(1);
                if (r_ptr == IDX_W'(ENTRIES - 1)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // One counter cell per entry; flush and update decode are local to each.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cell
        logic w_load;
        logic w_step;

        assign w_load = w_busy && (r_ptr == IDX_W'(gi));
        assign w_step = upd_valid && !w_busy && (upd_idx == IDX_W'(gi));

        sat_ctr_cell #(
            .CTR_W (CTR_W),
            .INIT  (INIT)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load),
            .i_step  (w_step),
            .i_truth (upd_truth),
            .o_ctr   (w_ctr[gi])
        );
    end

    // Read mux, optionally forwarding a same-index update into the result.
    always_comb begin
        w_rd_ctr = w_ctr[lookup_idx];
`ifdef SAT_CTR_BYPASS_EN
        if (upd_valid && (upd_idx == lookup_idx)) begin
            w_rd_ctr = CTR_W'(sat_next(MAX_CTR_W'(w_ctr[lookup_idx]), upd_truth, CTR_W));
        end
`endif
    end

    // Registered lookup result; data fields hold when no lookup is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid  <= 1'b0;
            r_pred_trust  <= 1'b0;
            r_pred_strong <= 1'b0;
            r_pred_ctr    <= '0;
        end else begin
            r_pred_valid <= w_lookup_ok;
            if (w_lookup_ok) begin
                r_pred_ctr    <= w_rd_ctr;
                r_pred_trust  <= (w_rd_ctr >= W_THRESH);
                r_pred_strong <= (w_rd_ctr == '0) || (w_rd_ctr == W_MAX);
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_trust  = r_pred_trust;
    assign pred_strong = r_pred_strong;
    assign pred_ctr    = r_pred_ctr;

endmodule

// File: doc/sat_counter_table.md
Name: sat_counter_table

Overview:
- Table of 2^IDX_W independent CTR_W-bit saturating confidence counters, each evaluating a stream of 1-bit truth/outcome reports.
- Generalises the single 2-bit trust FSM to configurable width and depth.
- Adds a registered lookup port, an update port, a strength indicator and a sequenced table flush.
- Used as a branch-direction / trust predictor inside the CPU front end.

Parameters:
- CTR_W, 2, counter width in bits, legal range 1..8.
- IDX_W, 4, index width; table depth ENTRIES = 2^IDX_W, legal range 1..10.
- INIT, 2^CTR_W-1, value loaded into every counter at reset and by flush; must be < 2^CTR_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_idx  in  IDX_W  entry to read.
- pred_valid  out  1  registered: lookup result valid this cycle.
- pred_trust  out  1  registered: counter MSB of looked-up entry (value >= 2^(CTR_W-1)).
- pred_strong  out  1  registered: looked-up counter is 0 or 2^CTR_W-1.
- pred_ctr  out  CTR_W  registered: raw counter value.
- upd_valid  in  1  update request this cycle.
- upd_idx  in  IDX_W  entry to update.
- upd_truth  in  1  observed outcome: 1 = increment, 0 = decrement.
- flush_req  in  1  single-cycle pulse to start a table flush.
- busy  out  1  flush in progress.

Behaviour:
- Reset, asynchronous on rst high:
  - All counters = INIT.
  - pred_valid, pred_trust, pred_strong, pred_ctr = 0.
  - busy = 0; FSM enters IDLE.
- Update, taking effect at the clock edge when upd_valid && !busy:
  - upd_truth=1: ctr = (ctr == 2^CTR_W-1) ? ctr : ctr+1.
  - upd_truth=0: ctr = (ctr == 0) ? 0 : ctr-1.
  - No wrap-around in either direction. Only entry upd_idx changes.
- Lookup, 1-cycle latency:
  - pred_valid(n+1) = lookup_valid(n) && !busy(n).
  - pred_trust/pred_strong/pred_ctr(n+1) are derived from entry lookup_idx as sampled at edge n (see Optional Feature for same-index collision).
  - If pred_valid is 0, the three data outputs hold their previous value.
- Flush FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on flush_req; sweep pointer = 0; busy = 1 from the next cycle.
  - In SWEEP, one entry per cycle: entry[ptr] = INIT, ptr++.
  - SWEEP -> IDLE after entry ENTRIES-1 is written; busy falls the cycle after. Flush therefore takes exactly ENTRIES cycles of busy.
  - flush_req while busy is ignored; the sweep does not restart.
  - Updates and lookups while busy are dropped: no state change, pred_valid = 0.
  - flush_req and upd_valid in the same IDLE cycle: the update applies first, then the sweep overwrites it.
- rst mid-sweep: immediate return to IDLE with all entries at INIT.
- CTR_W=1 degenerate case: the counter is a last-outcome bit; pred_strong is always 1.

Optional Feature:
- Macro SAT_CTR_BYPASS_EN.
- Defined: when lookup_valid && upd_valid && lookup_idx == upd_idx in the same non-busy cycle, the registered outputs show the post-update counter value (write-through forwarding).
- Undefined: in that case the outputs show the pre-update value; the update still commits.
- No other behaviour differs.

Decomposition:
- Shared package sat_ctr_pkg holds:
  - Flush FSM state enum (IDLE, SWEEP).
  - Function sat_next(ctr, truth) for the saturating step.
  - Constants CTR_MAX = 2^CTR_W-1 and TRUST_THRESH = 2^(CTR_W-1), width-parameterised via the function argument.
- One natural sub-module, sat_ctr_cell:
  - A single saturating counter with load-INIT and step inputs.
  - Instantiated ENTRIES times by a generate loop. Flush and update decode live in the top.

Test Plan:
- Reset, then lookup idx 3 -> next cycle pred_valid=1, pred_ctr=3, pred_trust=1, pred_strong=1 (defaults CTR_W=2, INIT=3).
- Four updates idx 5 truth=0, then lookup 5 -> pred_ctr=0, pred_trust=0, pred_strong=1; a fifth truth=0 update keeps pred_ctr=0.
- From 0, updates idx 5 truth=1,1,1,1 -> successive lookups read 1,2,3,3; trust goes high at 2; idx 4 and 6 stay at 3.
- Same-cycle lookup+update idx 7 truth=0 from 3 -> pred_ctr=2 with SAT_CTR_BYPASS_EN defined, 3 without; a later lookup reads 2 in both builds.
- Drive idx 0..15 to 0, then pulse flush_req -> busy high for exactly 16 cycles; updates/lookups during busy give pred_valid=0 and no change; afterwards all entries read 3.
- Assert rst asynchronously mid-sweep at ptr=8 and between edges -> busy and pred_valid drop immediately; all entries read INIT after release.
